// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns PCF, issues in-order word fetches, buffers responses, drives IF/ID.
// Optional FETCH_BYPASS_EN: a response arriving with an empty FIFO loads IF/ID directly in the same cycle.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = 8;

  logic [31:0]       pcF;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifoCount;
  logic [DROP_W-1:0] dropCnt;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [31:0]       fifoInstr [FIFO_DEPTH];
  logic [31:0]       fifoPc    [FIFO_DEPTH];

  logic        reqFire;
  logic        rspLive;
  logic        fifoPush;
  logic        fifoPop;
  logic        fifoEmpty;
  logic        fifoFull;
  logic        bypassLoad;
  logic [31:0] rspPc;
  logic [DROP_W-1:0] dropSum;

  assign imem_req_addr = {pcF[31:2], 2'b00};

  always_comb begin
    fifoEmpty = (fifoCount == '0);
    fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
    imem_req_valid = !reset && !StallF && !PCSrcE &&
                     (({1'b0, inflight} + {1'b0, fifoCount}) < (CNT_W+1)'(FIFO_DEPTH));
    reqFire = imem_req_valid && imem_req_ready;
    // Live requests are contiguous addresses, so the oldest one sits inflight words behind PCF.
    rspPc   = pcF - (32'(inflight) << 2);
    rspLive = imem_rsp_valid && !PCSrcE && (dropCnt == '0);
`ifdef FETCH_BYPASS_EN
    bypassLoad = rspLive && fifoEmpty && !StallD && !FlushD;
`else
    bypassLoad = 1'b0;
`endif
    fifoPush = rspLive && !bypassLoad;
    fifoPop  = !PCSrcE && !StallD && !FlushD && !fifoEmpty;
    dropSum  = dropCnt + DROP_W'(inflight);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF       <= RESET_PC;
      inflight  <= '0;
      dropCnt   <= '0;
      fifoCount <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else if (PCSrcE) begin
      // Everything still in flight now belongs to the squashed path.
      pcF       <= {PCTargetE[31:2], 2'b00};
      inflight  <= '0;
      dropCnt   <= (imem_rsp_valid && dropSum != '0) ? dropSum - DROP_W'(1) : dropSum;
      fifoCount <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else begin
      if (reqFire) pcF <= pcF + 32'd4;
      if (reqFire && !rspLive)      inflight <= inflight + CNT_W'(1);
      else if (!reqFire && rspLive) inflight <= inflight - CNT_W'(1);
      if (imem_rsp_valid && dropCnt != '0) dropCnt <= dropCnt - DROP_W'(1);
      if (fifoPush) wrPtr <= wrPtr + PTR_W'(1);
      if (fifoPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (fifoPush && !fifoPop)      fifoCount <= fifoCount + CNT_W'(1);
      else if (fifoPop && !fifoPush) fifoCount <= fifoCount - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fifoPush) begin
      fifoInstr[wrPtr] <= imem_rsp_data;
      fifoPc[wrPtr]    <= rspPc;
    end
  end

  // The issue rule keeps inflight + occupancy within depth, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifoPush && fifoFull));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
    end else if (PCSrcE) begin
      ValidD <= 1'b0;
      InstrD <= NOP_INSTR;
    end else if (!StallD) begin
      if (FlushD) begin
        ValidD <= 1'b0;
        InstrD <= NOP_INSTR;
      end else if (!fifoEmpty) begin
        ValidD   <= 1'b1;
        InstrD   <= fifoInstr[rdPtr];
        PCD      <= fifoPc[rdPtr];
        PCPlus4D <= fifoPc[rdPtr] + 32'd4;
      end else if (bypassLoad) begin
        ValidD   <= 1'b1;
        InstrD   <= imem_rsp_data;
        PCD      <= rspPc;
        PCPlus4D <= rspPc + 32'd4;
      end else begin
        ValidD <= 1'b0;
        InstrD <= NOP_INSTR;
      end
    end
  end

endmodule
